hd44780_refresh_sequencer: RTL and testbench
============================================

# hd44780_refresh_sequencer

Two-line character frame buffer and refresh sequencer sitting between user logic and `hd44780_controller`. User logic writes characters into an internal buffer at any time. On a refresh strobe the block replays the buffer to the LCD as set-DDRAM-address commands plus data bytes, issuing each byte through the controller's `STB_I`/`busy` handshake. It is the single owner of the controller's input side.

## Interface
- `LINE_LEN`, 16: characters per line; legal range 1..32.
- `CLK_I` in 1: system clock, from `hd44780_syscon` `CLK_O`.
- `RST_I` in 1: asynchronous, active-high reset, from syscon `RST_O`.
- `WE_I` in 1: buffer write enable, one write per cycle.
- `ADR_I` in 6: bit 5 selects the line; bits 4:0 select the column.
- `DAT_I` in 8: character code to write.
- `STB_I` in 1: refresh request, sampled only in IDLE.
- `busy` out 1: high from the cycle after an accepted request until `done`.
- `done` out 1: one-cycle pulse when the refresh completes.
- `o_stb` out 1: to controller `STB_I`.
- `o_rs` out 1: to controller `i_rs`; 0 = command, 1 = data.
- `o_data` out 8: to controller `i_lcd_data`.
- `i_cont_busy` in 1: from controller `busy`.

## Operation
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - All 2×`LINE_LEN` buffer bytes = 0x20 (space).
  - Dirty bits = 1.
- Writes:
  - Accepted in every state.
  - Columns ≥ `LINE_LEN` are ignored.
  - A write is visible to a transfer whose ISSUE happens in a later cycle.
- Transfer order per line L:
  - Command first: `o_rs`=0, `o_data` = 0x80 | (L ? 0x40 : 0x00).
  - Then columns 0..`LINE_LEN`-1: `o_rs`=1, `o_data` = buffer byte.
  - Line 0 precedes line 1.
- FSM states:
  - IDLE: if `STB_I`=1, go to SELECT.
  - SELECT: pick the next line to send. If none remains, pulse `done` and go to IDLE.
  - WAITRDY: wait for `i_cont_busy`=0.
  - ISSUE: load `o_rs`/`o_data`, drive `o_stb`=1 for exactly one cycle, go to ACK.
  - ACK: wait for `i_cont_busy`=1.
  - DRAIN: wait for `i_cont_busy`=0, then go to NEXT.
  - NEXT: advance column. After the last column go to SELECT, otherwise go to ISSUE.
- `o_rs`/`o_data` are held stable from ISSUE through DRAIN.
- Column counter is 5 bits and wraps only through NEXT→SELECT; it never exceeds `LINE_LEN`-1.
- `STB_I` while `busy`=1 is dropped, not queued.
- Reset mid-refresh:
  - Aborts immediately; `o_stb` falls asynchronously.
  - Buffer returns to spaces.
  - The controller's own reset is assumed simultaneous.

## Timing
- Request accepted at rising edge N. `busy`=1 and state SELECT at N+1.
- With the controller idle: WAITRDY at N+2, first `o_stb` at N+3.
- Per byte, the sequencer adds 2 cycles (ISSUE, NEXT) to the controller's busy time.
- Full refresh = 2×(`LINE_LEN`+1) strobes; 34 at the default.
- `done` is coincident with the last SELECT cycle. `busy` falls the cycle after `done`.
- ACK has no timeout. The controller must raise `busy` within one cycle of `STB_I`.

## Configuration
- `HD44780_DIRTY_EN` defined:
  - Each line has a dirty bit, set by any in-range write to that line.
  - The dirty bit is cleared when that line's command is issued.
  - SELECT skips clean lines.
  - A write landing after the clear re-marks the line dirty, so it is resent next refresh.
  - If both lines are clean: `done` at N+1, no `o_stb`.
- `HD44780_DIRTY_EN` undefined:
  - No dirty logic.
  - Both lines are always sent.

## Structure
- Shared package `hd44780_pkg` holds:
  - State enum.
  - `CMD_SET_DDRAM` = 8'h80.
  - `LINE1_BASE` = 7'h40.
- Sub-module `hd44780_char_buffer` holds the register array with asynchronous reset, the write port, a combinational read port, and the dirty bits.

## Test plan
- Reset, then `STB_I` → 34 strobes: 0x80, 16×0x20, 0xC0, 16×0x20; then `done`.
- Write 0x41 to line 0 col 0 and 0x5A to line 1 col 15, then refresh → byte 2 = 0x41 (`o_rs`=1), byte 34 = 0x5A.
- Write to col 20 with `LINE_LEN`=16 → buffer unchanged; refresh output identical to the reset frame.
- `STB_I` pulsed during refresh → ignored; exactly one `done`.
- With `HD44780_DIRTY_EN`: after a full refresh, write line 1 col 3, refresh → 17 strobes starting with 0xC0. A further refresh with no writes → `done` at N+1 and 0 strobes.
- Assert `RST_I` while in DRAIN → `o_stb`/`busy`/`done` = 0 immediately; a subsequent refresh sends the 34-byte space frame.

Source files
------------

// File: rtl/hd44780_pkg.sv
// Shared types and constants for the HD44780 refresh sequencer and its character buffer.
package hd44780_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAITRDY,
    ST_ISSUE,
    ST_ACK,
    ST_DRAIN,
    ST_NEXT
  } state_t;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [6:0] LINE1_BASE    = 7'h40;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;

  // Set-DDRAM-address command that positions the cursor at column 0 of a line.
  function automatic logic [7:0] ddram_cmd(input logic line);
    return CMD_SET_DDRAM | (line ? {1'b0, LINE1_BASE} : 8'h00);
  endfunction

endpackage

// File: rtl/hd44780_refresh_sequencer_if.sv
// User-side buffer/refresh port plus controller-side strobe port of the refresh sequencer.
interface hd44780_refresh_sequencer_if;
  logic       WE_I;
  logic [5:0] ADR_I;
  logic [7:0] DAT_I;
  logic       STB_I;
  logic       busy;
  logic       done;
  logic       o_stb;
  logic       o_rs;
  logic [7:0] o_data;
  logic       i_cont_busy;

  modport slave (
    input  WE_I, ADR_I, DAT_I, STB_I, i_cont_busy,
    output busy, done, o_stb, o_rs, o_data
  );

  modport master (
    output WE_I, ADR_I, DAT_I, STB_I, i_cont_busy,
    input  busy, done, o_stb, o_rs, o_data
  );
endinterface

// File: rtl/hd44780_char_buffer.sv
// Two-line character register array with write port, combinational read port and per-line
// dirty bits; the dirty tracking exists only when HD44780_DIRTY_EN is defined.
module hd44780_char_buffer
  import hd44780_pkg::*;
#(
  parameter int LINE_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [5:0] wr_adr,
  input  logic [7:0] wr_dat,
  input  logic       rd_line,
  input  logic [4:0] rd_col,
  output logic [7:0] rd_dat,
  input  logic       clr_dirty,
  input  logic       clr_line,
  output logic [1:0] dirty
);
  localparam int DEPTH = 2 * LINE_LEN;

  logic [7:0]       mem [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [5:0]       rd_idx;

  // Columns at or beyond LINE_LEN match no entry, so such writes fall away here.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      localparam logic       ROW = (gi >= LINE_LEN);
      localparam logic [4:0] COL = 5'(gi % LINE_LEN);
      assign hit[gi] = we && (wr_adr[5] == ROW) && (wr_adr[4:0] == COL);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= CHAR_SPACE;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (hit[i]) mem[i] <= wr_dat;
    end
  end

  assign rd_idx = {1'b0, rd_col} + (rd_line ? 6'(LINE_LEN) : 6'd0);

  always_comb begin
    rd_dat = CHAR_SPACE;
    for (int i = 0; i < DEPTH; i++) if (rd_idx == 6'(i)) rd_dat = mem[i];
  end

`ifdef HD44780_DIRTY_EN
  logic in_range;
  assign in_range = ({1'b0, wr_adr[4:0]} < 6'(LINE_LEN));

  // A write in the same cycle as the clear wins, so late data is resent next refresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dirty <= 2'b11;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (we && in_range && (wr_adr[5] == 1'(l)))  dirty[l] <= 1'b1;
        else if (clr_dirty && (clr_line == 1'(l)))  dirty[l] <= 1'b0;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_dirty, clr_line};
  assign dirty      = 2'b11;
`endif

endmodule

// File: rtl/hd44780_refresh_sequencer.sv
// Replays the two-line character buffer to hd44780_controller on each refresh request.
// Optional HD44780_DIRTY_EN: only lines written since their last transfer are resent.
module hd44780_refresh_sequencer
  import hd44780_pkg::*;
#(
  parameter int LINE_LEN = 16
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  hd44780_refresh_sequencer_if.slave   bus
);
  state_t     state_reg, state_next;
  logic       line_reg, line_next;
  logic [4:0] col_reg, col_next;
  logic       cmd_reg, cmd_next;
  logic [1:0] handled_reg, handled_next;
  logic       rs_reg;
  logic [7:0] data_reg;

  logic       done_w;
  logic [1:0] dirty;
  logic [1:0] pending;
  logic [7:0] rd_dat;
  logic [7:0] byte_next;

  hd44780_char_buffer #(.LINE_LEN(LINE_LEN)) u_buf (
    .clk       (CLK_I),
    .rst       (RST_I),
    .we        (bus.WE_I),
    .wr_adr    (bus.ADR_I),
    .wr_dat    (bus.DAT_I),
    .rd_line   (line_next),
    .rd_col    (col_next),
    .rd_dat    (rd_dat),
    .clr_dirty ((state_reg == ST_ISSUE) && cmd_reg),
    .clr_line  (line_reg),
    .dirty     (dirty)
  );

  assign pending = dirty & ~handled_reg;

  always_comb begin
    state_next   = state_reg;
    line_next    = line_reg;
    col_next     = col_reg;
    cmd_next     = cmd_reg;
    handled_next = handled_reg;
    done_w       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.STB_I) begin
          state_next   = ST_SELECT;
          handled_next = 2'b00;
        end
      end
      ST_SELECT: begin
        col_next = 5'd0;
        cmd_next = 1'b1;
        if (pending[0]) begin
          line_next    = 1'b0;
          handled_next = handled_reg | 2'b01;
          state_next   = ST_WAITRDY;
        end else if (pending[1]) begin
          line_next    = 1'b1;
          handled_next = 2'b11;
          state_next   = ST_WAITRDY;
        end else begin
          done_w     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAITRDY: if (!bus.i_cont_busy) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_ACK;
      ST_ACK:     if (bus.i_cont_busy) state_next = ST_DRAIN;
      ST_DRAIN:   if (!bus.i_cont_busy) state_next = ST_NEXT;
      ST_NEXT: begin
        if (cmd_reg) begin
          cmd_next   = 1'b0;
          state_next = ST_ISSUE;
        end else if (col_reg == 5'(LINE_LEN - 1)) begin
          col_next   = 5'd0;
          state_next = ST_SELECT;
        end else begin
          col_next   = col_reg + 5'd1;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bypass a same-cycle write so it reaches the ISSUE that follows it.
  assign byte_next = (bus.WE_I && (bus.ADR_I[5] == line_next) && (bus.ADR_I[4:0] == col_next))
                     ? bus.DAT_I : rd_dat;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_reg   <= ST_IDLE;
      line_reg    <= 1'b0;
      col_reg     <= 5'd0;
      cmd_reg     <= 1'b0;
      handled_reg <= 2'b00;
      rs_reg      <= 1'b0;
      data_reg    <= 8'h00;
    end else begin
      state_reg   <= state_next;
      line_reg    <= line_next;
      col_reg     <= col_next;
      cmd_reg     <= cmd_next;
      handled_reg <= handled_next;
      if (state_next == ST_ISSUE) begin
        rs_reg   <= ~cmd_next;
        data_reg <= cmd_next ? ddram_cmd(line_next) : byte_next;
      end
    end
  end

  assign bus.busy   = (state_reg != ST_IDLE);
  assign bus.done   = done_w;
  assign bus.o_stb  = (state_reg == ST_ISSUE);
  assign bus.o_rs   = rs_reg;
  assign bus.o_data = data_reg;

endmodule

// File: tb/tb_hd44780_refresh_sequencer.sv
// Directed bench for hd44780_refresh_sequencer with a small controller busy model.
module tb_hd44780_refresh_sequencer;
  localparam int LINE_LEN = 16;
  localparam int BUSY_CYC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hd44780_refresh_sequencer_if bus();

  hd44780_refresh_sequencer #(.LINE_LEN(LINE_LEN)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Controller model: raises busy the edge after a strobe and holds it BUSY_CYC cycles.
  int unsigned busy_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_cont_busy <= 1'b0;
      busy_cnt        <= 0;
    end else if (bus.o_stb) begin
      bus.i_cont_busy <= 1'b1;
      busy_cnt        <= BUSY_CYC;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) bus.i_cont_busy <= 1'b0;
    end
  end

  logic [8:0] cap_q[$];
  int         done_cnt = 0;
  always @(negedge clk) begin
    if (bus.o_stb) cap_q.push_back({bus.o_rs, bus.o_data});
    if (bus.done)  done_cnt <= done_cnt + 1;
  end

  logic [7:0] m_buf [2*LINE_LEN];
  logic [1:0] m_dirty;
  logic       busy_n1, stb_n2, stb_n3;
  logic [8:0] data_n3;
  int         done_cyc;

  task automatic model_reset();
    for (int i = 0; i < 2*LINE_LEN; i++) m_buf[i] = 8'h20;
    m_dirty = 2'b11;
  endtask

  task automatic wr(input logic line, input int col, input logic [7:0] dat);
    @(negedge clk);
    bus.WE_I  = 1'b1;
    bus.ADR_I = {line, 5'(col)};
    bus.DAT_I = dat;
    @(negedge clk);
    bus.WE_I = 1'b0;
    if (col < LINE_LEN) begin
      m_buf[int'(line)*LINE_LEN + col] = dat;
      m_dirty[line] = 1'b1;
    end
    $display("write line=%0d col=%0d dat=0x%02h", line, col, dat);
  endtask

  task automatic run_refresh(input string tag, input bit poke);
    logic [8:0] exp_q[$];
    bit         send;
    bit         got_done;
    int         d0;
    int         cyc;
    for (int l = 0; l < 2; l++) begin
`ifdef HD44780_DIRTY_EN
      send = m_dirty[l];
      m_dirty[l] = 1'b0;
`else
      send = 1'b1;
`endif
      if (send) begin
        exp_q.push_back((l == 1) ? 9'h0C0 : 9'h080);
        for (int c = 0; c < LINE_LEN; c++) exp_q.push_back({1'b1, m_buf[l*LINE_LEN + c]});
      end
    end
    cap_q.delete();
    d0       = done_cnt;
    got_done = 1'b0;
    @(negedge clk);
    bus.STB_I = 1'b1;
    for (cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.STB_I = 1'b0;
        busy_n1   = bus.busy;
      end
      if (cyc == 2) stb_n2 = bus.o_stb;
      if (cyc == 3) begin
        stb_n3  = bus.o_stb;
        data_n3 = {bus.o_rs, bus.o_data};
      end
      if (poke && (cyc == 40 || cyc == 41)) bus.STB_I = (cyc == 40);
      #1;
      if (done_cnt != d0) begin
        got_done = 1'b1;
        break;
      end
    end
    done_cyc = cyc;
    check({tag, "_done_seen"}, 32'(got_done), 1);
    if (got_done) begin
      check({tag, "_busy_with_done"}, 32'(bus.busy), 1);
      @(negedge clk); #1;
      check({tag, "_busy_after_done"}, 32'(bus.busy), 0);
    end
    repeat (10) @(negedge clk);
    #1;
    check({tag, "_done_count"}, 32'(done_cnt - d0), 1);
    check({tag, "_strobes"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i),
            (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    $display("refresh %s strobes=%0d expected=%0d done_cycle=%0d", tag, cap_q.size(),
             exp_q.size(), done_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    bus.WE_I  = 1'b0;
    bus.ADR_I = 6'd0;
    bus.DAT_I = 8'd0;
    bus.STB_I = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",   32'(bus.busy),   0);
    check("rst_done",   32'(bus.done),   0);
    check("rst_stb",    32'(bus.o_stb),  0);
    check("rst_rs",     32'(bus.o_rs),   0);
    check("rst_data",   32'(bus.o_data), 0);

    run_refresh("frame0", 1'b0);
    check("t_busy_n1",     32'(busy_n1), 1);
    check("t_stb_n2",      32'(stb_n2),  0);
    check("t_stb_n3",      32'(stb_n3),  1);
    check("t_first_byte",  32'(data_n3), 32'h080);

    wr(1'b0, 20, 8'h7E);
    run_refresh("col20", 1'b0);

    wr(1'b0, 0, 8'h41);
    wr(1'b1, 15, 8'h5A);
    run_refresh("chars", 1'b0);
    check("chars_byte2",  (cap_q.size() > 1)  ? 32'(cap_q[1])  : 32'hFFFF_FFFF, 32'h141);
    check("chars_byte34", (cap_q.size() > 33) ? 32'(cap_q[33]) : 32'hFFFF_FFFF, 32'h15A);

    run_refresh("poke", 1'b1);

`ifdef HD44780_DIRTY_EN
    wr(1'b1, 3, 8'h33);
    run_refresh("dirty1", 1'b0);
    check("dirty1_count", 32'(cap_q.size()), 17);
    check("dirty1_first", (cap_q.size() > 0) ? 32'(cap_q[0]) : 32'hFFFF_FFFF, 32'h0C0);
    run_refresh("clean", 1'b0);
    check("clean_done_n1", 32'(done_cyc), 1);
    check("clean_count",   32'(cap_q.size()), 0);
`endif

    wr(1'b0, 5, 8'h55);
    @(negedge clk);
    bus.STB_I = 1'b1;
    @(negedge clk);
    bus.STB_I = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_stb) begin
        seen = 1'b1;
        break;
      end
    end
    check("drain_stb_seen", 32'(seen), 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("drain_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("arst_stb",  32'(bus.o_stb),  0);
    check("arst_busy", 32'(bus.busy),   0);
    check("arst_done", 32'(bus.done),   0);
    check("arst_data", 32'(bus.o_data), 0);
    $display("reset asserted during DRAIN");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_refresh("after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
